// File: rtl/skullfet_tester.sv
// Inverter-cell tester: drives a pattern into one cell, samples its synchronized output and counts mismatches.
// Optional LFSR pattern source when SKULLFET_LFSR_EN is defined; otherwise the pattern is always alternating.
module skullfet_tester #(
    parameter int CNT_W    = 16,
    parameter int SETTLE_W = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [SETTLE_W-1:0] settle,
    input  logic [CNT_W-1:0]    num_vec,
    input  logic                mode,
    output logic                dut_a,
    input  logic                dut_y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    err_count,
    output logic [CNT_W-1:0]    vec_count
);

    // state  | meaning
    // IDLE   | waiting for start
    // DRIVE  | apply next pattern bit, load settle counter
    // SETTLE | wait settle+2 cycles for cell and synchronizer
    // SAMPLE | compare synced output, count vector
    // DONE   | one-cycle completion, pass updated
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [SETTLE_W:0] CNT_ONE = (SETTLE_W+1)'(1);
    localparam logic [SETTLE_W:0] CNT_TWO = (SETTLE_W+1)'(2);
    localparam logic [CNT_W-1:0]  ALL_ONES = '1;

    state_t              r_state;
    state_t              w_next;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_dut_a;
    logic                r_pass;
    logic [CNT_W-1:0]    r_err;
    logic [CNT_W-1:0]    r_vec;
    logic [CNT_W-1:0]    r_num_vec;
    logic [SETTLE_W-1:0] r_settle;
    logic [SETTLE_W:0]   r_cnt;

    logic                w_abort;
    logic                w_mismatch;
    logic                w_next_bit;
    logic [CNT_W-1:0]    w_vec_inc;

    assign w_abort    = abort && (r_state != ST_IDLE);
    assign w_mismatch = (r_sync2 == r_dut_a);
    assign w_vec_inc  = r_vec + 1'b1;

`ifdef SKULLFET_LFSR_EN
    logic       r_mode;
    logic [7:0] r_lfsr;
    logic       w_fb;
    logic [7:0] w_lfsr_next;

    // Taps 8,6,5,4; the bit shifted in is the new pattern bit.
    assign w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_lfsr_next = {r_lfsr[6:0], w_fb};
    assign w_next_bit  = r_mode ? w_lfsr_next[0] : ~r_dut_a;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_mode <= 1'b0;
            r_lfsr <= 8'h01;
        end else if (r_state == ST_IDLE && start) begin
            r_mode <= mode;
            r_lfsr <= 8'h01;
        end else if (r_state == ST_DRIVE && !w_abort) begin
            r_lfsr <= w_lfsr_next;
        end
    end
`else
    logic w_mode_unused;

    assign w_mode_unused = mode;
    assign w_next_bit    = ~r_dut_a;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= dut_y;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (num_vec == '0) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE:  w_next = ST_SETTLE;
            ST_SETTLE: begin
                if (r_cnt == CNT_ONE) begin
                    w_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: w_next = (w_vec_inc == r_num_vec) ? ST_DONE : ST_DRIVE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_dut_a   <= 1'b0;
            r_pass    <= 1'b0;
            r_err     <= '0;
            r_vec     <= '0;
            r_num_vec <= '0;
            r_settle  <= '0;
            r_cnt     <= '0;
        end else if (w_abort) begin
            // Counts hold so software can see how far the run got.
            r_dut_a <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_settle  <= settle;
                        r_num_vec <= num_vec;
                        r_err     <= '0;
                        r_vec     <= '0;
                        r_pass    <= 1'b0;
                        r_dut_a   <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    r_dut_a <= w_next_bit;
                    r_cnt   <= {1'b0, r_settle} + CNT_TWO;
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt - CNT_ONE;
                end
                ST_SAMPLE: begin
                    if (w_mismatch && r_err != ALL_ONES) begin
                        r_err <= r_err + 1'b1;
                    end
                    r_vec <= w_vec_inc;
                end
                ST_DONE: begin
                    r_pass <= (r_err == '0);
                end
                default: ;
            endcase
        end
    end

    assign dut_a     = r_dut_a;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign err_count = r_err;
    assign vec_count = r_vec;

endmodule

// File: tb/tb_skullfet_tester.sv
// Scoreboard bench for skullfet_tester: runs queue expected results, a negedge monitor checks them on done.
// Define SKULLFET_LFSR_EN for both files to exercise the LFSR pattern.
module tb_skullfet_tester;

    localparam int CNT_W    = 8;
    localparam int SETTLE_W = 4;
`ifdef SKULLFET_LFSR_EN
    localparam bit LFSR_ON = 1'b1;
`else
    localparam bit LFSR_ON = 1'b0;
`endif

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [SETTLE_W-1:0] settle = '0;
    logic [CNT_W-1:0]    num_vec = '0;
    logic                mode = 1'b0;
    logic                dut_a;
    logic                dut_y;
    logic                busy;
    logic                done;
    logic                pass;
    logic [CNT_W-1:0]    err_count;
    logic [CNT_W-1:0]    vec_count;

    // ymode 0: loopback with per-vector flips from mask, 1: tied low, 2: tied high
    int           ymode = 0;
    logic [255:0] mask = '0;
    assign dut_y = (ymode == 0) ? (~dut_a ^ mask[vec_count]) : (ymode == 2);

    skullfet_tester #(.CNT_W(CNT_W), .SETTLE_W(SETTLE_W)) u_dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_n (wb_rst_n),
        .start    (start),
        .abort    (abort),
        .settle   (settle),
        .num_vec  (num_vec),
        .mode     (mode),
        .dut_a    (dut_a),
        .dut_y    (dut_y),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .vec_count(vec_count)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc = 0;
    always @(posedge wb_clk_i) cyc++;

    typedef struct {
        int           start_cyc;
        int           lat;
        int           err;
        int           n;
        logic [255:0] seq;
    } exp_t;

    exp_t sb[$];
    logic obs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] pattern(input int n, input bit use_lfsr);
        logic [255:0] p;
        int           st;
        int           fb;
        int           taps[4];
        p = '0;
        st = 1;
        taps = '{8, 6, 5, 4};
        for (int i = 0; i < n; i++) begin
            if (use_lfsr) begin
                fb = 0;
                foreach (taps[t]) fb ^= (st >> (taps[t] - 1)) & 1;
                st = ((st << 1) | fb) & 8'hFF;
                p[i] = fb[0];
            end else begin
                p[i] = (i % 2 == 0);
            end
        end
        return p;
    endfunction

    bit exp_pass_pend = 0;
    int exp_pass_val  = 0;
    bit prev_busy     = 0;
    int prev_vec      = 0;

    always @(negedge wb_clk_i) begin
        exp_t e;
        int   bad_idx;
        if (wb_rst_n) begin
            if (exp_pass_pend) begin
                chk("pass", int'(pass), exp_pass_val);
                exp_pass_pend = 0;
            end
            if (busy && !prev_busy) obs.delete();
            if (int'(vec_count) != prev_vec && vec_count != 0) obs.push_back(dut_a);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc - e.start_cyc, e.lat);
                    chk("err_count", int'(err_count), e.err);
                    chk("vec_count", int'(vec_count), e.n);
                    chk("seq_len", obs.size(), e.n);
                    bad_idx = -1;
                    for (int i = 0; i < e.n && i < obs.size(); i++)
                        if (bad_idx < 0 && obs[i] != e.seq[i]) bad_idx = i;
                    chk("dut_a_seq_first_bad_idx", bad_idx, -1);
                    if (e.n == 0) chk("dut_a_zero_run", int'(dut_a), 0);
                    exp_pass_pend = 1;
                    exp_pass_val  = (e.err == 0);
                end
            end
        end
        prev_busy = busy;
        prev_vec  = int'(vec_count);
    end

    task automatic run(input int n, input int s, input bit m, input int ym,
                       input logic [255:0] mk, input bit poke);
        exp_t e;
        int   k;
        int   budget;
        @(negedge wb_clk_i);
        ymode   = ym;
        mask    = mk;
        settle  = SETTLE_W'(s);
        num_vec = CNT_W'(n);
        mode    = m;
        start   = 1'b1;
        e.start_cyc = cyc + 1;
        e.lat = n * (s + 4);
        e.n   = n;
        e.seq = pattern(n, m && LFSR_ON);
        e.err = 0;
        for (int i = 0; i < n; i++) begin
            if (ym == 0) e.err += int'(mk[i]);
            else if (ym == 1) e.err += int'(!e.seq[i]);
            else e.err += int'(e.seq[i]);
        end
        sb.push_back(e);
        @(negedge wb_clk_i);
        start   = 1'b0;
        settle  = SETTLE_W'($urandom);
        num_vec = CNT_W'($urandom);
        mode    = 1'($urandom);
        if (poke) begin
            repeat (3) @(negedge wb_clk_i);
            start = 1'b1;
            @(negedge wb_clk_i);
            start = 1'b0;
        end
        budget = e.lat + 20;
        k = 0;
        while (busy && k < budget) begin
            @(negedge wb_clk_i);
            k++;
        end
        if (busy) begin
            chk("run_timeout", 1, 0);
            $display("FAIL run_timeout: busy still high after %0d cycles", budget);
            $fatal(1, "timeout");
        end
        @(negedge wb_clk_i);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int s;
        logic [255:0] mk;
        repeat (3) @(negedge wb_clk_i);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_vec", int'(vec_count), 0);
        chk("rst_dut_a", int'(dut_a), 0);
        wb_rst_n = 1'b1;
        repeat (2) @(negedge wb_clk_i);

        run(4, 0, 1'b0, 0, '0, 1'b0);
        run(4, 3, 1'b0, 1, '0, 1'b0);
        run(0, 2, 1'b0, 0, '0, 1'b0);
        run(15, 1, 1'b0, 2, '0, 1'b1);
        run(3, 15, 1'b0, 0, '0, 1'b0);
        run(255, 0, 1'b1, 0, '0, 1'b0);
        run(20, 1, 1'b1, 2, '0, 1'b0);

        for (int r = 0; r < 14; r++) begin
            mk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run(int'($urandom_range(0, 24)), int'($urandom_range(0, 7)), 1'($urandom),
                int'($urandom_range(0, 2)), mk, 1'b0);
        end

        // abort in 3rd vector's SETTLE
        s = 2;
        @(negedge wb_clk_i);
        ymode = 0; mask = '0; settle = SETTLE_W'(s); num_vec = 8'd10; mode = 1'b0;
        start = 1'b1;
        @(posedge wb_clk_i);
        repeat (2 * (s + 4) + 1) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        start = 1'b0;
        abort = 1'b1;
        @(negedge wb_clk_i);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_pass", int'(pass), 0);
        chk("abort_vec", int'(vec_count), 2);
        chk("abort_err", int'(err_count), 0);
        chk("abort_dut_a", int'(dut_a), 0);
        repeat (4) @(negedge wb_clk_i);
        chk("abort_stays_idle", int'(busy), 0);

        // reset mid-run
        @(negedge wb_clk_i);
        num_vec = 8'd8; settle = 4'd1; start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        repeat (11) @(negedge wb_clk_i);
        wb_rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_vec", int'(vec_count), 0);
        chk("midrst_dut_a", int'(dut_a), 0);
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        chk("midrst_idle", int'(busy), 0);

        run(5, 0, 1'b0, 0, 256'h5, 1'b0);
        chk("sb_final", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
